// File: rtl/baser_257b_gen_if.sv
// Transmit-side handshake bundle for the 257b transcoded block generator.
// Keeps the spec-fixed signal names; master = generator, slave = consumer.
interface baser_257b_gen_if #(
  parameter int TC_WIDTH = 257
) ();
  logic [TC_WIDTH-1:0] o_tx_coded;
  logic                o_valid;
  logic                o_done;
  logic                i_ready;

  modport master (output o_tx_coded, output o_valid, output o_done, input i_ready);
  modport slave  (input o_tx_coded, input o_valid, input o_done, output i_ready);
endinterface

// File: rtl/baser_257b_gen.sv
// 256b/257b transcoded test-pattern generator: builds one 257-bit block per
// accepted handshake from a selectable control mask, with burst/stop control and statistics.
module baser_257b_gen #(
  parameter int         DATA_WIDTH        = 64,
  parameter int         TC_DATA_WIDTH     = 4*DATA_WIDTH,
  parameter int         SH_WIDTH          = 1,
  parameter int         TC_WIDTH          = TC_DATA_WIDTH + SH_WIDTH,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'h00,
  parameter logic [7:0] CTRL_CHAR_PATTERN = 8'hFF
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_mode,
  input  logic [3:0]  i_ctrl_mask,
  input  logic        i_err_inject,
  input  logic [15:0] i_burst_len,
  baser_257b_gen_if.master tx_if,
  output logic [31:0] o_block_count,
  output logic [31:0] o_data_count,
  output logic [31:0] o_ctrl_count,
  output logic [31:0] o_inv_block_count
);

  localparam int PL_W = TC_DATA_WIDTH - 4;
  localparam logic [TC_DATA_WIDTH-1:0] DATA_FILL = {(TC_DATA_WIDTH/8){DATA_CHAR_PATTERN}};
  localparam logic [DATA_WIDTH-1:0]    DATA_BLK  = {(DATA_WIDTH/8){DATA_CHAR_PATTERN}};
  localparam logic [DATA_WIDTH-1:0]    CTRL_BLK  = {(DATA_WIDTH/8){CTRL_CHAR_PATTERN}};
  localparam logic [TC_WIDTH-1:0]      RESET_TX  = TC_WIDTH'({DATA_FILL, 1'b1});
  localparam logic [TC_WIDTH-1:0]      INV_TX    = TC_WIDTH'({DATA_FILL[PL_W-1:0], 4'hF, 1'b0});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [TC_WIDTH-1:0] tx_q, tx_d;
  logic                valid_q, done_q;
  logic [15:0]         run_cnt_q, run_cnt_d;
  logic                stop_q, stop_d;
  logic                err_q, err_d;
  logic [1:0]          walk_idx_q, walk_idx_d;
  logic [3:0]          lfsr_q, lfsr_d;

  logic                accept, load, burst_hit, err_pend;
  logic [3:0]          load_mask;
  logic [4:0]          ctrl_seen;
  logic [PL_W-1:0]     payload;

  assign accept    = valid_q & tx_if.i_ready;
  assign burst_hit = (i_burst_len != 16'd0) && ((run_cnt_q + 16'd1) == i_burst_len);
  assign err_pend  = err_q | i_err_inject;

  // Sequences step on every accepted block; a load uses the already-stepped value.
  assign walk_idx_d = accept ? walk_idx_q + 2'd1 : walk_idx_q;
  assign lfsr_d     = accept ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;

  always_comb begin
    load_mask = 4'hF;
    case (i_mode)
      2'b00:   load_mask = 4'hF;
      2'b01:   load_mask = i_ctrl_mask;
      2'b10:   load_mask = ~(4'b0001 << walk_idx_d);
      default: load_mask = lfsr_d;
    endcase
  end

  // ctrl_seen[i]: some block below index i is control, so block i is not the shortened one.
  assign ctrl_seen[0] = 1'b0;
  for (genvar gi = 0; gi < 4; gi++) begin : g_seen
    assign ctrl_seen[gi+1] = ctrl_seen[gi] | ~load_mask[gi];
  end

  always_comb begin
    payload = '0;
    for (int i = 3; i >= 0; i--) begin
      if (load_mask[i])
        payload = (payload << DATA_WIDTH) | PL_W'(DATA_BLK);
      else if (!ctrl_seen[i])
        payload = (payload << (DATA_WIDTH-4)) | PL_W'(CTRL_BLK[DATA_WIDTH-5:0]);
      else
        payload = (payload << DATA_WIDTH) | PL_W'(CTRL_BLK);
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    stop_d    = stop_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = RUN;
          run_cnt_d = 16'd0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (i_stop) stop_d = 1'b1;
        if (accept) begin
          run_cnt_d = run_cnt_q + 16'd1;
          if (burst_hit)           state_d = DONE;
          else if (stop_q || i_stop) state_d = IDLE;
          else                     load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != RUN) stop_d = 1'b0;
  end

  always_comb begin
    tx_d  = tx_q;
    err_d = err_pend;
    if (load) begin
      err_d = 1'b0;
      if (err_pend)          tx_d = INV_TX;
      else if (&load_mask)   tx_d = RESET_TX;
      else                   tx_d = TC_WIDTH'({payload, load_mask, 1'b0});
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tx_q       <= RESET_TX;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      run_cnt_q  <= 16'd0;
      stop_q     <= 1'b0;
      err_q      <= 1'b0;
      walk_idx_q <= 2'd0;
      lfsr_q     <= 4'b1001;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      valid_q    <= (state_d == RUN);
      done_q     <= (state_d == DONE);
      run_cnt_q  <= run_cnt_d;
      stop_q     <= stop_d;
      err_q      <= err_d;
      walk_idx_q <= walk_idx_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign tx_if.o_tx_coded = tx_q;
  assign tx_if.o_valid    = valid_q;
  assign tx_if.o_done     = done_q;

  // Statistics: block, data, control, invalid -- classified from the block being accepted.
  logic [3:0]  cnt_inc;
  logic [31:0] cnt_vec [4];

  assign cnt_inc[0] = accept;
  assign cnt_inc[1] = accept & tx_q[0];
  assign cnt_inc[2] = accept & ~tx_q[0] & (tx_q[4:1] != 4'hF);
  assign cnt_inc[3] = accept & ~tx_q[0] & (tx_q[4:1] == 4'hF);

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst)
        cnt_q <= 32'd0;
      else if (cnt_inc[gi] && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
    end
    assign cnt_vec[gi] = cnt_q;
  end

  assign o_block_count     = cnt_vec[0];
  assign o_data_count      = cnt_vec[1];
  assign o_ctrl_count      = cnt_vec[2];
  assign o_inv_block_count = cnt_vec[3];

endmodule

// File: tb/tb_baser_257b_gen.sv
// Randomized directed bench for baser_257b_gen against a bit-level reference
// of the 257b block format and sequence rules.
module tb_baser_257b_gen;
  localparam logic [7:0] DP = 8'h00;
  localparam logic [7:0] CP = 8'hFF;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_stop, i_err_inject;
  logic [1:0]  i_mode;
  logic [3:0]  i_ctrl_mask;
  logic [15:0] i_burst_len;
  logic [31:0] blk_c, data_c, ctrl_c, inv_c;

  baser_257b_gen_if #(.TC_WIDTH(257)) bus ();

  baser_257b_gen dut (
    .clk               (clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .i_stop            (i_stop),
    .i_mode            (i_mode),
    .i_ctrl_mask       (i_ctrl_mask),
    .i_err_inject      (i_err_inject),
    .i_burst_len       (i_burst_len),
    .tx_if             (bus.master),
    .o_block_count     (blk_c),
    .o_data_count      (data_c),
    .o_ctrl_count      (ctrl_c),
    .o_inv_block_count (inv_c)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned m_acc, m_blk, m_data, m_ctrl, m_inv;
  bit          m_err;
  logic [3:0]  lfsr_tbl [15];

  task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference block built bit by bit from the format rules.
  function automatic logic [256:0] ref_block(input logic [3:0] m, input bit err);
    logic [256:0] b;
    logic [7:0]   pat;
    int           pos, len;
    bit           first;
    b = '0;
    if (err) begin
      b[4:1] = 4'hF;
      for (int p = 5; p <= 256; p++) b[p] = DP[(p-5)%8];
    end else if (m == 4'hF) begin
      b[0] = 1'b1;
      for (int p = 1; p <= 256; p++) b[p] = DP[(p-1)%8];
    end else begin
      b[4:1] = m;
      pos = 5;
      first = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          len = 64; pat = DP;
        end else begin
          len = first ? 60 : 64; pat = CP; first = 1'b0;
        end
        for (int k = 0; k < len; k++) b[pos+k] = pat[k%8];
        pos += len;
      end
    end
    return b;
  endfunction

  function automatic logic [3:0] seq_mask(input logic [1:0] mode, input logic [3:0] fixed);
    logic [3:0] one = 4'b0001;
    case (mode)
      2'b00:   return 4'hF;
      2'b01:   return fixed;
      2'b10:   return ~(one << (m_acc % 4));
      default: return lfsr_tbl[m_acc % 15];
    endcase
  endfunction

  task automatic count_block(input logic [256:0] b);
    m_blk++;
    if (b[0])                  m_data++;
    else if (b[4:1] != 4'hF)   m_ctrl++;
    else                       m_inv++;
  endtask

  task automatic check_counters();
    check("block_count", 257'(blk_c),  257'(m_blk));
    check("data_count",  257'(data_c), 257'(m_data));
    check("ctrl_count",  257'(ctrl_c), 257'(m_ctrl));
    check("inv_count",   257'(inv_c),  257'(m_inv));
  endtask

  task automatic check_reset_outputs();
    logic [255:0] fill = {32{DP}};
    check("rst_tx",    bus.o_tx_coded, {fill, 1'b1});
    check("rst_valid", 257'(bus.o_valid), 257'(0));
    check("rst_done",  257'(bus.o_done),  257'(0));
    check_counters();
  endtask

  // Asserts reset between clock edges so outputs must react without a clock.
  task automatic do_reset();
    i_rst = 1'b1;
    bus.i_ready = 1'b0;
    i_start = 1'b0; i_stop = 1'b0; i_err_inject = 1'b0;
    #1;
    m_acc = 0; m_blk = 0; m_data = 0; m_ctrl = 0; m_inv = 0; m_err = 1'b0;
    check_reset_outputs();
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 257'(bus.o_valid), 257'(0));
  endtask

  task automatic run(input logic [1:0] mode, input logic [3:0] fmask, input int burst,
                     input int rdy_pct, input int lo_start, input int lo_len,
                     input int err_cyc, input int stop_cyc);
    logic [256:0] exp;
    int cnt = 0;
    bit stop_m = 1'b0;
    bit fin = 1'b0;
    bit rdy, inj, stp;
    i_mode = mode; i_ctrl_mask = fmask; i_burst_len = 16'(burst); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    exp = ref_block(seq_mask(mode, fmask), m_err);
    m_err = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      check("valid", 257'(bus.o_valid), 257'(1));
      check("tx", bus.o_tx_coded, exp);
      check_counters();
      rdy = ($urandom_range(99) < rdy_pct) && !(cyc >= lo_start && cyc < lo_start + lo_len);
      inj = (cyc == err_cyc);
      stp = (cyc == stop_cyc);
      bus.i_ready = rdy; i_err_inject = inj; i_stop = stp;
      i_start = 1'($urandom_range(1));
      @(posedge clk); #1;
      i_err_inject = 1'b0; i_stop = 1'b0; i_start = 1'b0;
      if (inj) m_err = 1'b1;
      if (stp) stop_m = 1'b1;
      if (rdy) begin
        count_block(exp);
        m_acc++;
        cnt++;
        if (burst != 0 && cnt == burst) begin
          check("done_pulse", 257'(bus.o_done),  257'(1));
          check("done_valid", 257'(bus.o_valid), 257'(0));
          bus.i_ready = 1'b0;
          @(posedge clk); #1;
          check("done_clear", 257'(bus.o_done),  257'(0));
          check("idle_valid", 257'(bus.o_valid), 257'(0));
          fin = 1'b1;
        end else if (stop_m) begin
          check("stop_no_done", 257'(bus.o_done),  257'(0));
          check("stop_valid",   257'(bus.o_valid), 257'(0));
          fin = 1'b1;
        end else begin
          exp = ref_block(seq_mask(mode, fmask), m_err);
          m_err = 1'b0;
        end
      end
    end
    check("run_finished", 257'(fin), 257'(1));
    bus.i_ready = 1'b0;
    check_counters();
    $display("run mode=%0d mask=%b burst=%0d accepted=%0d total_blocks=%0d", mode, fmask, burst, cnt, m_blk);
  endtask

  initial begin
    logic [3:0] s;
    s = 4'b1001;
    for (int i = 0; i < 15; i++) begin
      lfsr_tbl[i] = s;
      s = {s[2:0], s[3] ^ s[2]};
    end
    i_mode = 2'b00; i_ctrl_mask = 4'h0; i_burst_len = 16'd0;
    do_reset();

    run(2'b00, 4'h0,    3, 100, -1, 0, -1, -1);
    run(2'b01, 4'b1110, 1, 100, -1, 0, -1, -1);
    run(2'b01, 4'b0101, 1, 100, -1, 0, -1, -1);

    do_reset();
    run(2'b10, 4'h0,    0, 100, -1, 0, -1,  4);
    run(2'b10, 4'h0,   10, 100,  3, 5, -1, -1);
    run(2'b11, 4'h0,   20,  60, -1, 0, -1, -1);
    run(2'b00, 4'h0,    6, 100, -1, 0,  2, -1);
    run(2'b01, 4'b1010, 0, 100,  3, 4, -1,  3);

    for (int r = 0; r < 6; r++)
      run(2'($urandom_range(3)), 4'($urandom_range(15)), int'($urandom_range(8, 1)),
          int'($urandom_range(100, 40)), -1, 0, int'($urandom_range(6)), -1);

    i_mode = 2'b11; i_burst_len = 16'd10; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    check_counters();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/baser_257b_gen.md
BASER_257B_GEN -- requirements
Module: baser_257b_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one 64b block payload.
REQ-002 SHALL have parameter TC_DATA_WIDTH, default 4*DATA_WIDTH, transcoded payload width without header.
REQ-003 SHALL have parameter SH_WIDTH, default 1, transcoded header width.
REQ-004 SHALL have parameter TC_WIDTH, default TC_DATA_WIDTH+SH_WIDTH, full 257b block width.
REQ-005 SHALL have parameter DATA_CHAR_PATTERN, default 8'h00, byte used to fill data blocks.
REQ-006 SHALL have parameter CTRL_CHAR_PATTERN, default 8'hFF, byte used to fill control blocks.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port i_start, input, 1, start pulse.
REQ-010 SHALL have port i_stop, input, 1, stop request.
REQ-011 SHALL have port i_mode, input, 2, mask source: 00 all-data, 01 fixed, 10 walking, 11 LFSR.
REQ-012 SHALL have port i_ctrl_mask, input, 4, fixed mask for mode 01.
REQ-013 SHALL have port i_err_inject, input, 1, request one invalid block.
REQ-014 SHALL have port i_burst_len, input, 16, number of blocks per run; 0 = continuous.
REQ-015 SHALL have port i_ready, input, 1, downstream accept.
REQ-016 SHALL have ports o_tx_coded (output, TC_WIDTH, block), o_valid (output, 1), o_done (output, 1, end-of-burst pulse).
REQ-017 SHALL have outputs o_block_count, o_data_count, o_ctrl_count, o_inv_block_count, each 32 bits, counting accepted blocks.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; i_start in IDLE moves to RUN next edge; i_start in RUN or DONE is ignored.
REQ-019 SHALL register o_tx_coded/o_valid: first block valid the cycle after i_start is sampled; o_valid=1 only in RUN.
REQ-020 SHALL treat a block as accepted when o_valid && i_ready; the next block is loaded on that edge, giving back-to-back throughput of one block per cycle.
REQ-021 SHALL hold o_tx_coded stable while o_valid && !i_ready.
REQ-022 SHALL encode mask 4'b1111 (any mode) as bit0=1, bits[256:1] = 32 x DATA_CHAR_PATTERN.
REQ-023 SHALL encode any other mask as bit0=0, bits[4:1]=mask (bit i = 0 means 64b block i is control), payload from bit 5 in block order 0..3.
REQ-024 SHALL emit the lowest-index control block as 60 bits of CTRL_CHAR_PATTERN, later control blocks as 64 bits, data blocks as 64 bits of DATA_CHAR_PATTERN (total exactly 257 bits).
REQ-025 SHALL select mask at block load: mode 00 -> 1111; 01 -> i_ctrl_mask sampled then; 10 -> 1110,1101,1011,0111 repeating, advancing per accepted block; 11 -> 4-bit LFSR x^4+x^3+1, seed 4'b1001, advancing per accepted block.
REQ-026 SHALL latch i_err_inject (sticky) and apply it to the next loaded block: bit0=0, bits[4:1]=1111, bits[256:5] data pattern; latch clears on that load; walking/LFSR sequence still advances.
REQ-027 SHALL, on acceptance, increment o_block_count always; o_data_count if bit0=1; o_ctrl_count if bit0=0 and mask!=1111; o_inv_block_count if bit0=0 and mask=1111; all saturate at 32'hFFFF_FFFF.
REQ-028 SHALL count accepted blocks per run (16-bit); when i_burst_len!=0 and the count reaches i_burst_len, go to DONE, o_valid=0, assert o_done for one cycle, then IDLE.
REQ-029 SHALL latch i_stop in RUN and return to IDLE (no o_done) after the pending block is accepted; stop and acceptance in the same cycle -> IDLE next edge.
REQ-030 SHALL give burst completion priority over stop when both occur on the same acceptance (DONE, o_done asserted).
REQ-031 SHALL clear the per-run count on entry to RUN; statistics counters are never cleared by i_start.

Reset
REQ-032 SHALL, on i_rst asserted (any time, asynchronously), force state IDLE, o_valid=0, o_done=0, all counters 0, LFSR=4'b1001, walking index 0, error and stop latches 0, o_tx_coded = {32 x DATA_CHAR_PATTERN, 1'b1}.
REQ-033 SHALL discard any in-flight block on reset without counting it.

Verification
REQ-034 Mode 00, burst 3, i_ready=1 -> three blocks bit0=1 on consecutive cycles; counts block=3 data=3; o_done pulse one cycle after third acceptance.
REQ-035 Mode 01 mask 1110, burst 1 -> bit0=0, [4:1]=1110, [64:5]=60 x 1, [256:65]=0; ctrl_count=1.
REQ-036 Mode 10 mask 0101 check via mode 01 -> [68:5]=0, [128:69]=all 1, [192:129]=0, [256:193]=all 1; walking mode continuous -> masks 1110,1101,1011,0111,1110.
REQ-037 i_ready low 5 cycles mid-run -> o_tx_coded unchanged, counters unchanged, then resumes with next sequence mask.
REQ-038 i_err_inject pulse in mode 00 -> next block bit0=0,[4:1]=1111; inv_count=1, data_count excludes it.
REQ-039 i_stop with i_ready=0, then i_ready=1 -> one more acceptance, IDLE, o_done=0; i_rst mid-burst -> all outputs to reset values same cycle.
